// File: rtl/window_feeder.sv
// rtl/window_feeder.sv - assembles a raster pixel stream into 16x16 windows in two ping-pong banks
// and hands each window to the matcher with a ready/done handshake.
module window_feeder #(
    parameter int NUM_WINDOWS = 150,
    parameter int IDX_W       = 9
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [7:0]                pix_in,
    input  logic                      pix_valid,
    output logic                      pix_ready,
    output logic [15:0][15:0][7:0]    window_data_out,
    output logic                      window_data_ready,
    input  logic                      done_with_window_data,
    output logic [IDX_W-1:0]          window_index,
    output logic                      busy,
    output logic                      frame_done
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WINDOWS - 1);
    localparam logic [IDX_W:0]   NUM_W    = (IDX_W + 1)'(NUM_WINDOWS);
    localparam logic [IDX_W-1:0] ONE      = IDX_W'(1);

    state_t                        state_q, state_d;
    logic [1:0][15:0][15:0][7:0]   bank_q;
    logic [1:0]                    full_q, full_d;
    logic                          fill_bank_q, fill_bank_d;
    logic                          pres_bank_q, pres_bank_d;
    logic [7:0]                    pix_cnt_q, pix_cnt_d;
    logic [IDX_W-1:0]              filled_cnt_q, filled_cnt_d;
    logic [IDX_W-1:0]              sent_cnt_q, sent_cnt_d;
    logic                          frame_done_q, frame_done_d;

    logic accept, fill_last, rel_win, last_rel;

    assign pix_ready = (state_q == RUN) & ~full_q[fill_bank_q] & ({1'b0, filled_cnt_q} < NUM_W);
    assign accept    = pix_valid & pix_ready;
    assign fill_last = accept & (pix_cnt_q == 8'hFF);
    assign rel_win   = (state_q == RUN) & done_with_window_data & full_q[pres_bank_q];
    assign last_rel  = rel_win & (sent_cnt_q == LAST_IDX);

    assign window_data_ready = full_q[pres_bank_q];
    assign window_data_out   = bank_q[pres_bank_q];
    assign window_index      = sent_cnt_q;
    assign busy              = (state_q == RUN);
    assign frame_done        = frame_done_q;

    always_comb begin
        state_d      = state_q;
        full_d       = full_q;
        fill_bank_d  = fill_bank_q;
        pres_bank_d  = pres_bank_q;
        pix_cnt_d    = pix_cnt_q;
        filled_cnt_d = filled_cnt_q;
        sent_cnt_d   = sent_cnt_q;
        frame_done_d = last_rel;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = RUN;
                    full_d       = 2'b00;
                    fill_bank_d  = 1'b0;
                    pres_bank_d  = 1'b0;
                    pix_cnt_d    = 8'd0;
                    filled_cnt_d = '0;
                    sent_cnt_d   = '0;
                end
            end
            RUN: begin
                if (accept) begin
                    pix_cnt_d = pix_cnt_q + 8'd1;
                end
                // fill and release never target the same bank, so both may apply in one cycle
                if (fill_last) begin
                    full_d[fill_bank_q] = 1'b1;
                    fill_bank_d         = ~fill_bank_q;
                    filled_cnt_d        = filled_cnt_q + ONE;
                end
                if (rel_win) begin
                    full_d[pres_bank_q] = 1'b0;
                    pres_bank_d         = ~pres_bank_q;
                    sent_cnt_d          = sent_cnt_q + ONE;
                end
                if (last_rel) begin
                    state_d    = IDLE;
                    sent_cnt_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            full_q       <= 2'b00;
            fill_bank_q  <= 1'b0;
            pres_bank_q  <= 1'b0;
            pix_cnt_q    <= 8'd0;
            filled_cnt_q <= '0;
            sent_cnt_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            full_q       <= full_d;
            fill_bank_q  <= fill_bank_d;
            pres_bank_q  <= pres_bank_d;
            pix_cnt_q    <= pix_cnt_d;
            filled_cnt_q <= filled_cnt_d;
            sent_cnt_q   <= sent_cnt_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_q <= '0;
        end else if (accept) begin
            bank_q[fill_bank_q][pix_cnt_q[7:4]][pix_cnt_q[3:0]] <= pix_in;
        end
    end

endmodule

// File: tb/tb_window_feeder.sv
// tb/tb_window_feeder.sv - self-checking bench for window_feeder with a window-queue reference model.
module tb_window_feeder;

    localparam int N = 3;

    typedef logic [15:0][15:0][7:0] win_t;

    typedef struct {
        logic       s;
        logic       pv;
        logic [7:0] pin;
        logic       d;
        logic       e_pr;
        logic       e_busy;
        logic       e_rdy;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  pix_in;
    logic        pix_valid;
    logic        pix_ready;
    win_t        window_data_out;
    logic        window_data_ready;
    logic        done_with_window_data;
    logic [8:0]  window_index;
    logic        busy;
    logic        frame_done;

    int n_vec = 0;
    int n_bad = 0;

    // reference model: a queue of completed windows awaiting the matcher
    int   m_run, m_pix, m_filled, m_sent;
    bit   m_fd;
    win_t m_part;
    win_t m_q[$];

    window_feeder #(.NUM_WINDOWS(N), .IDX_W(9)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .start                 (start),
        .pix_in                (pix_in),
        .pix_valid             (pix_valid),
        .pix_ready             (pix_ready),
        .window_data_out       (window_data_out),
        .window_data_ready     (window_data_ready),
        .done_with_window_data (done_with_window_data),
        .window_index          (window_index),
        .busy                  (busy),
        .frame_done            (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_win(input string name, input win_t act, input win_t exp);
        bit found;
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            found = 0;
            for (int r = 0; r < 16; r++)
                for (int c = 0; c < 16; c++)
                    if (!found && act[r][c] !== exp[r][c]) begin
                        found = 1;
                        $display("FAIL %s: [%0d][%0d] got %0h expected %0h at %0t",
                                 name, r, c, act[r][c], exp[r][c], $time);
                    end
        end
    endtask

    function automatic win_t win_const(input logic [7:0] v);
        win_t w;
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                w[r][c] = v;
        return w;
    endfunction

    function automatic win_t win_ramp(input bit down);
        win_t w;
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                w[r][c] = down ? 8'(255 - (r * 16 + c)) : 8'(r * 16 + c);
        return w;
    endfunction

    function automatic bit m_pr();
        return (m_run != 0) && (m_q.size() < 2) && (m_filled < N);
    endfunction

    task automatic model_reset();
        m_run = 0; m_pix = 0; m_filled = 0; m_sent = 0; m_fd = 0;
        m_part = '0;
        m_q.delete();
    endtask

    task automatic model_step(input logic s, input logic pv, input logic [7:0] pin, input logic d);
        bit   acc, rel;
        win_t tmp;
        acc  = pv && m_pr();
        m_fd = 0;
        if (m_run == 0) begin
            if (s) begin
                m_run = 1; m_pix = 0; m_filled = 0; m_sent = 0;
                m_q.delete();
            end
        end else begin
            rel = d && (m_q.size() > 0);
            if (rel) tmp = m_q.pop_front();
            if (acc) begin
                m_part[m_pix / 16][m_pix % 16] = pin;
                m_pix++;
                if (m_pix == 256) begin
                    m_q.push_back(m_part);
                    m_pix = 0;
                    m_filled++;
                end
            end
            if (rel) begin
                m_sent++;
                if (m_sent == N) begin
                    m_run = 0;
                    m_fd  = 1;
                end
            end
        end
    endtask

    task automatic compare_model();
        chk("pix_ready", pix_ready, m_pr());
        chk("window_data_ready", window_data_ready, m_q.size() > 0);
        chk("busy", busy, m_run != 0);
        chk("frame_done", frame_done, m_fd);
        if (m_q.size() > 0) begin
            chk("window_index", window_index, m_sent);
            chk_win("window_data_out", window_data_out, m_q[0]);
        end
    endtask

    task automatic cycle(input logic s, input logic pv, input logic [7:0] pin, input logic d);
        start = s; pix_valid = pv; pix_in = pin; done_with_window_data = d;
        model_step(s, pv, pin, d);
        @(posedge clk);
        #1;
        start = 0; pix_valid = 0; done_with_window_data = 0;
        compare_model();
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_pix_ready"}, pix_ready, 0);
        chk({tag, "_ready"}, window_data_ready, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_index"}, window_index, 0);
        chk_win({tag, "_data"}, window_data_out, '0);
    endtask

    // asserts rst between edges so the clearing is seen before any clock
    task automatic do_reset(input string tag);
        rst = 1;
        model_reset();
        #2;
        check_cleared(tag);
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    vec_t tbl[6];

    initial begin
        tbl[0] = '{s:0, pv:1, pin:8'h05, d:0, e_pr:0, e_busy:0, e_rdy:0};
        tbl[1] = '{s:0, pv:0, pin:8'h00, d:1, e_pr:0, e_busy:0, e_rdy:0};
        tbl[2] = '{s:1, pv:0, pin:8'h00, d:0, e_pr:1, e_busy:1, e_rdy:0};
        tbl[3] = '{s:1, pv:1, pin:8'h07, d:0, e_pr:1, e_busy:1, e_rdy:0};
        tbl[4] = '{s:0, pv:1, pin:8'h08, d:0, e_pr:1, e_busy:1, e_rdy:0};
        tbl[5] = '{s:0, pv:0, pin:8'h00, d:1, e_pr:1, e_busy:1, e_rdy:0};

        rst = 1; start = 0; pix_valid = 0; pix_in = 0; done_with_window_data = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_cleared("reset_held");
        rst = 0;
        @(posedge clk);
        #1;
        check_cleared("reset_released");

        for (int i = 0; i < 6; i++) begin
            cycle(tbl[i].s, tbl[i].pv, tbl[i].pin, tbl[i].d);
            chk($sformatf("tbl%0d_pix_ready", i), pix_ready, tbl[i].e_pr);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
            chk($sformatf("tbl%0d_ready", i), window_data_ready, tbl[i].e_rdy);
        end

        // single window, ramp data
        do_reset("pre_single");
        cycle(1, 0, 8'h00, 0);
        for (int k = 0; k < 256; k++) cycle(0, 1, 8'(k), 0);
        chk("single_ready", window_data_ready, 1);
        chk("single_index", window_index, 0);
        chk("single_pix_ready", pix_ready, 1);
        chk_win("single_data", window_data_out, win_ramp(0));

        // ping-pong backpressure, simultaneous events, frame end
        do_reset("pre_pingpong");
        cycle(1, 0, 8'h00, 0);
        for (int k = 0; k < 256; k++) cycle(0, 1, 8'h11, 0);
        for (int k = 0; k < 256; k++) cycle(0, 1, 8'h22, 0);
        chk("both_full_pix_ready", pix_ready, 0);
        for (int k = 0; k < 4; k++) cycle(0, 1, 8'h33, 0);
        chk("held_pix_ready", pix_ready, 0);
        chk_win("held_data_A", window_data_out, win_const(8'h11));
        cycle(0, 1, 8'h33, 1);
        chk("after_done_ready", window_data_ready, 1);
        chk("after_done_index", window_index, 1);
        chk("after_done_pix_ready", pix_ready, 1);
        chk_win("after_done_data_B", window_data_out, win_const(8'h22));
        for (int k = 0; k < 255; k++) cycle(0, 1, 8'h33, 0);
        cycle(0, 1, 8'h33, 1);
        chk("simul_ready", window_data_ready, 1);
        chk("simul_index", window_index, 2);
        chk("simul_pix_ready_last", pix_ready, 0);
        chk_win("simul_data_C", window_data_out, win_const(8'h33));
        for (int k = 0; k < 3; k++) cycle(0, 1, 8'h44, 0);
        chk("last_filled_pix_ready", pix_ready, 0);
        cycle(0, 1, 8'h44, 1);
        chk("frame_done_pulse", frame_done, 1);
        chk("frame_end_busy", busy, 0);
        chk("frame_end_ready", window_data_ready, 0);
        cycle(0, 1, 8'h44, 0);
        chk("frame_done_one_cycle", frame_done, 0);
        chk("frame_end_pix_ready", pix_ready, 0);

        // reset mid-frame, then a fresh frame
        do_reset("pre_midframe");
        cycle(1, 0, 8'h00, 0);
        for (int k = 0; k < 100; k++) cycle(0, 1, 8'hA5, 0);
        do_reset("midframe");
        cycle(1, 0, 8'h00, 0);
        for (int k = 0; k < 256; k++) cycle(0, 1, 8'(255 - k), 0);
        chk("restart_ready", window_data_ready, 1);
        chk("restart_index", window_index, 0);
        chk_win("restart_data", window_data_out, win_ramp(1));

        // randomized frames against the model
        for (int f = 0; f < 2; f++) begin
            bit finished;
            do_reset("pre_random");
            cycle(1, 0, 8'h00, 0);
            finished = 0;
            for (int c = 0; c < 6000 && !finished; c++) begin
                cycle($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
                      8'($urandom_range(0, 255)), $urandom_range(0, 3) == 0);
                if (m_fd) finished = 1;
            end
            n_vec++;
            if (!finished) begin
                n_bad++;
                $display("FAIL random_frame_timeout: frame %0d got no frame end, required one within 6000 cycles", f);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/window_feeder.md
# window_feeder

Upstream stage of the NCC matcher. Accepts a raster pixel stream of search windows from the frame-memory reader, one 8-bit pixel per beat, and assembles each group of 256 pixels into a 16x16 window in one of two ping-pong banks. It presents complete windows to the matcher's window port via the ready/done handshake, counts windows per frame, and pulses `frame_done` after the last window is consumed.

## Interface

Parameters:
- `NUM_WINDOWS`, default 150: windows per frame. Legal range is 1..511.
- `IDX_W`, default 9: width of the window index.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `start`, in, 1: single-cycle pulse that begins a frame. Accepted only in IDLE.
- `pix_in`, in, 8: pixel data, unsigned.
- `pix_valid`, in, 1: `pix_in` is valid.
- `pix_ready`, out, 1: the block accepts a pixel this cycle. A beat transfers when `pix_valid & pix_ready`.
- `window_data_out`, out, 8 x [15:0][15:0]: the presented window. Indexed [row][col].
- `window_data_ready`, out, 1: `window_data_out` holds a complete window.
- `done_with_window_data`, in, 1: the matcher has consumed the presented window (1-cycle pulse).
- `window_index`, out, IDX_W: index of the presented window, 0..NUM_WINDOWS-1.
- `busy`, out, 1: the block is in RUN.
- `frame_done`, out, 1: 1-cycle pulse after the last window is released.

## Operation

State machine:
- IDLE: `start` moves the FSM to RUN. On entry to RUN, all counters and full flags are cleared.
- RUN: returns to IDLE at the same edge that releases window NUM_WINDOWS-1. `frame_done` is registered and goes high for the following cycle.
- `start` during RUN is ignored.

Storage:
- Two banks (0 and 1), each 16x16x8 bits.
- `full[1:0]` flags; `fill_bank` and `pres_bank` pointers, both 0 after entering RUN.
- `pix_cnt`, 8 bits; `filled_cnt` and `sent_cnt`, IDX_W bits each.

Fill rules:
- `pix_ready = (state==RUN) & ~full[fill_bank] & (filled_cnt < NUM_WINDOWS)`.
- Beat k (k = `pix_cnt`) writes `bank[fill_bank][k[7:4]][k[3:0]]`, so pixels arrive row-major with column 0 first.
- On beat 255: set `full[fill_bank]`, toggle `fill_bank`, increment `filled_cnt`, and `pix_cnt` wraps to 0.

Present rules:
- `window_data_ready = full[pres_bank]`.
- `window_data_out = bank[pres_bank]` (a mux of registers).
- `window_index = sent_cnt`.
- `done_with_window_data` with `window_data_ready` high: clear `full[pres_bank]`, toggle `pres_bank`, increment `sent_cnt`.
- `done_with_window_data` with `window_data_ready` low is ignored.

Boundary conditions:
- **Simultaneous events.** A fill completing into one bank and a release of the other bank in the same cycle both take effect. Fill never targets a full bank, so the two events never collide on the same bank.
- **Both banks full.** `pix_ready` is 0 until a release occurs.
- **Last window filled.** `pix_ready` stays 0 for the rest of the frame, even if `pix_valid` is held high.
- **Reset mid-frame.** All state returns to reset values immediately and partial windows are discarded.

Reset values:
- FSM is IDLE.
- `pix_ready`, `window_data_ready`, `busy` and `frame_done` are 0.
- `window_index` is 0.
- Both banks are all-zero, so `window_data_out` is 0.

## Timing

- **Fill latency.** The last beat is accepted at edge t, and `window_data_ready` is 1 in the cycle after t.
- **Handshake.** The matcher samples the window on a cycle where ready=1 and pulses done the next cycle. `window_data_out` and `window_index` are stable from the cycle `window_data_ready` rises through the cycle `done_with_window_data` is high.
- **After done.**
  - If the other bank is full: `window_data_ready` stays 1, and the next window and index are valid the next cycle.
  - Otherwise: `window_data_ready` is 0 the next cycle.
  - A release therefore never leaves ready high with stale data.
- **Throughput.** One pixel per cycle with no bubbles while a bank is free. The steady state is 256 cycles per window.
- **Start latency.** `start` is sampled at edge t, and `busy` and `pix_ready` can be 1 in the cycle after t.

## Test plan

Run each scenario with NUM_WINDOWS=3 unless stated otherwise.

1. **Reset values.** Hold `rst` high, then release it. All outputs read 0, and `pix_ready`=0 until `start`.
2. **Single window.** Pulse `start`, then stream pixels 0..255 with no gaps. One cycle after the last beat, `window_data_ready`=1, `window_data_out[r][c]`=16r+c, and `window_index`=0.
3. **Ping-pong backpressure.** Stream windows A (all 0x11), B (all 0x22) and C (all 0x33) while withholding `done`. `pix_ready` drops after B's beat 255. Pulse `done`: the next cycle shows B with `window_index`=1 and ready still 1, and `pix_ready`=1.
4. **Frame end.** Consume all three windows. `frame_done` is high exactly 1 cycle after the third `done`. `busy` is then 0, and the 4th window's pixels are never accepted.
5. **Simultaneous events and stray done.** Pulse `done` on the same cycle as the final beat of the next window; both flags update correctly. A `done` pulse while ready=0 changes nothing.
6. **Reset mid-frame.** Assert `rst` after 100 beats. Outputs are cleared. Then `start` and a fresh window stream produce `window_index`=0 with correct data.
